// File: rtl/int_vect_exit.sv
// Interrupt-return sequencer: a PC write of RET_MAGIC pops CEX, PSW, LR and PC off the stack.
// Build macro IV_EXIT_SP_WRAP_CHECK_EN stops the sequence with stk_fault instead of letting SP wrap.
module int_vect_exit #(
    parameter int          STEP      = 2,
    parameter logic [15:0] RET_MAGIC = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_we_in,
    input  logic [15:0] pc_wdata,
    input  logic [15:0] sp_in,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] sp_out,
    output logic        sp_we,
    output logic [15:0] cex_out,
    output logic        cex_we,
    output logic [15:0] psw_out,
    output logic        psw_we,
    output logic [15:0] lr_out,
    output logic        lr_we,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic        stall,
    output logic        done,
    output logic        stk_fault
);
    typedef enum logic [2:0] {IDLE, POP_CEX, POP_PSW, POP_LR, POP_PC, DONE} state_t;

    localparam logic [15:0] STEP16 = 16'(STEP);

    state_t      r_state;
    logic [15:0] r_sp;
    logic [15:0] r_mem_addr;
    logic        r_mem_req;
    logic [15:0] r_sp_out, r_cex_out, r_psw_out, r_lr_out, r_pc_out;
    logic        r_sp_we, r_cex_we, r_psw_we, r_lr_we, r_pc_we;
    logic        r_stall;
    logic        r_done;

    logic [15:0] w_sp_inc;
    logic [15:0] w_addr_nxt;
    logic [15:0] w_trig_addr;
    logic        w_trigger;
    logic        w_accept;
    logic        w_wrap_cur;
    logic        w_wrap_nxt;
    logic        w_wrap_trig;

    assign w_sp_inc    = r_sp + STEP16;
    assign w_addr_nxt  = w_sp_inc + STEP16;
    assign w_trig_addr = sp_in + STEP16;
    assign w_trigger   = pc_we_in && (pc_wdata == RET_MAGIC);
    assign w_accept    = r_mem_req && mem_ack;

`ifdef IV_EXIT_SP_WRAP_CHECK_EN
    // A sum smaller than its operand means the 16-bit add carried out.
    assign w_wrap_cur  = (w_sp_inc < r_sp);
    assign w_wrap_nxt  = (w_addr_nxt < w_sp_inc);
    assign w_wrap_trig = (w_trig_addr < sp_in);

    logic r_stk_fault;
    assign stk_fault = r_stk_fault;
`else
    assign w_wrap_cur  = 1'b0;
    assign w_wrap_nxt  = 1'b0;
    assign w_wrap_trig = 1'b0;
    assign stk_fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sp       <= '0;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_sp_out   <= '0;
            r_cex_out  <= '0;
            r_psw_out  <= '0;
            r_lr_out   <= '0;
            r_pc_out   <= '0;
            r_sp_we    <= 1'b0;
            r_cex_we   <= 1'b0;
            r_psw_we   <= 1'b0;
            r_lr_we    <= 1'b0;
            r_pc_we    <= 1'b0;
            r_stall    <= 1'b0;
            r_done     <= 1'b0;
`ifdef IV_EXIT_SP_WRAP_CHECK_EN
            r_stk_fault <= 1'b0;
`endif
        end else begin
            r_sp_we  <= 1'b0;
            r_cex_we <= 1'b0;
            r_psw_we <= 1'b0;
            r_lr_we  <= 1'b0;
            r_pc_we  <= 1'b0;
`ifdef IV_EXIT_SP_WRAP_CHECK_EN
            r_stk_fault <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_sp       <= sp_in;
                        r_mem_addr <= w_trig_addr;
                        r_mem_req  <= !w_wrap_trig;
                        r_stall    <= 1'b1;
                        r_state    <= POP_CEX;
                    end
                end
                POP_CEX, POP_PSW, POP_LR, POP_PC: begin
                    // A pop whose address would wrap was never requested; abandon it here.
                    if (w_wrap_cur) begin
`ifdef IV_EXIT_SP_WRAP_CHECK_EN
                        r_stk_fault <= 1'b1;
`endif
                        r_mem_req <= 1'b0;
                        r_state   <= DONE;
                    end else if (w_accept) begin
                        r_sp       <= w_sp_inc;
                        r_sp_out   <= w_sp_inc;
                        r_sp_we    <= 1'b1;
                        r_mem_addr <= w_addr_nxt;
                        r_mem_req  <= (r_state != POP_PC) && !w_wrap_nxt;
                        case (r_state)
                            POP_CEX: begin
                                r_cex_out <= mem_rdata;
                                r_cex_we  <= 1'b1;
                                r_state   <= POP_PSW;
                            end
                            POP_PSW: begin
                                r_psw_out <= mem_rdata;
                                r_psw_we  <= 1'b1;
                                r_state   <= POP_LR;
                            end
                            POP_LR: begin
                                r_lr_out <= mem_rdata;
                                r_lr_we  <= 1'b1;
                                r_state  <= POP_PC;
                            end
                            default: begin
                                r_pc_out <= mem_rdata;
                                r_pc_we  <= 1'b1;
                                r_state  <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    // First DONE cycle lets the last strobe retire; done pulses in the second.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_stall <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign sp_out   = r_sp_out;
    assign sp_we    = r_sp_we;
    assign cex_out  = r_cex_out;
    assign cex_we   = r_cex_we;
    assign psw_out  = r_psw_out;
    assign psw_we   = r_psw_we;
    assign lr_out   = r_lr_out;
    assign lr_we    = r_lr_we;
    assign pc_out   = r_pc_out;
    assign pc_we    = r_pc_we;
    assign stall    = r_stall;
    assign done     = r_done;

endmodule

// File: tb/tb_int_vect_exit.sv
// Directed bench for int_vect_exit: a memory responder with configurable wait states plus per-cycle strobe logging.
module tb_int_vect_exit;
    logic        clk;
    logic        rst_n;
    logic        pc_we_in;
    logic [15:0] pc_wdata;
    logic [15:0] sp_in;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] sp_out, cex_out, psw_out, lr_out, pc_out;
    logic        sp_we, cex_we, psw_we, lr_we, pc_we;
    logic        stall, done, stk_fault;

    int checks = 0;
    int errors = 0;
    int nwait  = 0;

    int          we_n[4];
    int          we_k[4];
    logic [15:0] we_v[4];
    logic [15:0] we_sp[4];
    int          done_n, done_k, fault_n, fault_k, req_n, stall_n, bad_n;

    int_vect_exit dut (
        .clk(clk), .rst_n(rst_n), .pc_we_in(pc_we_in), .pc_wdata(pc_wdata), .sp_in(sp_in),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .sp_out(sp_out), .sp_we(sp_we), .cex_out(cex_out), .cex_we(cex_we),
        .psw_out(psw_out), .psw_we(psw_we), .lr_out(lr_out), .lr_we(lr_we),
        .pc_out(pc_out), .pc_we(pc_we), .stall(stall), .done(done), .stk_fault(stk_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h7FF2: mem_rd = 16'h0003;
            16'h7FF4: mem_rd = 16'h60E0;
            16'h7FF6: mem_rd = 16'h1234;
            16'h7FF8: mem_rd = 16'h0A00;
            16'hFFFC: mem_rd = 16'hC0DE;
            16'hFFFE: mem_rd = 16'h5A5A;
            16'h0000: mem_rd = 16'h1111;
            16'h0002: mem_rd = 16'h2222;
            default:  mem_rd = 16'hDEAD;
        endcase
    endfunction

    // Memory responder: acks after nwait low cycles and checks the address holds while waiting.
    initial begin
        int          wcnt;
        logic [15:0] hold_addr;
        wcnt = 0;
        hold_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (wcnt == 0) hold_addr = mem_addr;
                else chk("addr_stable", 128'(mem_addr), 128'(hold_addr));
                if (wcnt >= nwait) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = '0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic run_seq(input logic [15:0] sp, input logic [15:0] wdata, input int nw,
                           input int retrig_k, input int rst_k, input int ncyc);
        logic [3:0]  w;
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            we_n[i] = 0; we_k[i] = -1; we_v[i] = '0; we_sp[i] = '0;
        end
        done_n = 0; done_k = -1; fault_n = 0; fault_k = -1; req_n = 0; stall_n = 0; bad_n = 0;
        nwait = nw;
        @(negedge clk);
        sp_in = sp; pc_wdata = wdata; pc_we_in = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) pc_we_in = 1'b0;
            w = {pc_we, lr_we, psw_we, cex_we};
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0: v = cex_out;
                    1: v = psw_out;
                    2: v = lr_out;
                    default: v = pc_out;
                endcase
                if (w[i]) begin
                    if (we_n[i] == 0) begin we_k[i] = k; we_v[i] = v; we_sp[i] = sp_out; end
                    we_n[i]++;
                end
            end
            if ($countones(w) > 1 || sp_we != (|w)) bad_n++;
            if (done) begin if (done_n == 0) done_k = k; done_n++; end
            if (stk_fault) begin if (fault_n == 0) fault_k = k; fault_n++; end
            if (mem_req) req_n++;
            if (stall) stall_n++;
            if (k == retrig_k) begin pc_we_in = 1'b1; pc_wdata = 16'hFFFF; end
            else if (k == retrig_k + 1) pc_we_in = 1'b0;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_zero", {mem_req, mem_addr, sp_out, sp_we, cex_out, cex_we, psw_out, psw_we,
                    lr_out, lr_we, pc_out, pc_we, stall, done, stk_fault}, '0);
            end else if (k == rst_k + 1) rst_n = 1'b1;
        end
    endtask

    task automatic chk_pop(input int i, input int k, input logic [15:0] v, input logic [15:0] sp);
        chk($sformatf("pop%0d_count", i), 128'(we_n[i]), 128'(1));
        chk($sformatf("pop%0d_cycle", i), 128'(we_k[i]), 128'(k));
        chk($sformatf("pop%0d_data", i), 128'(we_v[i]), 128'(v));
        chk($sformatf("pop%0d_sp", i), 128'(we_sp[i]), 128'(sp));
    endtask

    initial begin
        rst_n = 1'b1; pc_we_in = 1'b0; pc_wdata = '0; sp_in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {mem_req, mem_addr, sp_out, sp_we, cex_out, cex_we, psw_out, psw_we,
            lr_out, lr_we, pc_out, pc_we, stall, done, stk_fault}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic return, zero-wait
        run_seq(16'h7FF0, 16'hFFFF, 0, 0, 0, 12);
        chk_pop(0, 2, 16'h0003, 16'h7FF2);
        chk_pop(1, 3, 16'h60E0, 16'h7FF4);
        chk_pop(2, 4, 16'h1234, 16'h7FF6);
        chk_pop(3, 5, 16'h0A00, 16'h7FF8);
        chk("basic_done_cycle", 128'(done_k), 128'(6));
        chk("basic_done_count", 128'(done_n), 128'(1));
        chk("basic_req_cycles", 128'(req_n), 128'(4));
        chk("basic_stall_cycles", 128'(stall_n), 128'(6));
        chk("basic_strobe_exclusive", 128'(bad_n), 128'(0));
        chk("basic_no_fault", 128'(fault_n), 128'(0));
        $display("basic return: done at T+%0d", done_k);

        // Three wait cycles per read
        run_seq(16'h7FF0, 16'hFFFF, 3, 0, 0, 24);
        chk_pop(0, 5, 16'h0003, 16'h7FF2);
        chk_pop(1, 9, 16'h60E0, 16'h7FF4);
        chk_pop(2, 13, 16'h1234, 16'h7FF6);
        chk_pop(3, 17, 16'h0A00, 16'h7FF8);
        chk("wait_done_cycle", 128'(done_k), 128'(18));
        chk("wait_req_cycles", 128'(req_n), 128'(16));
        chk("wait_strobe_exclusive", 128'(bad_n), 128'(0));
        $display("wait states: pc_we at T+%0d done at T+%0d", we_k[3], done_k);

        // PC write of a non-magic value
        run_seq(16'h7FF0, 16'hFFFE, 0, 0, 0, 10);
        chk("nontrig_strobes", 128'(we_n[0] + we_n[1] + we_n[2] + we_n[3]), 128'(0));
        chk("nontrig_req", 128'(req_n), 128'(0));
        chk("nontrig_stall", 128'(stall_n), 128'(0));
        chk("nontrig_done", 128'(done_n), 128'(0));
        $display("non-trigger: stall cycles %0d", stall_n);

        // Second trigger during POP_PSW
        run_seq(16'h7FF0, 16'hFFFF, 0, 2, 0, 14);
        chk("retrig_cex_n", 128'(we_n[0]), 128'(1));
        chk("retrig_psw_n", 128'(we_n[1]), 128'(1));
        chk("retrig_lr_n", 128'(we_n[2]), 128'(1));
        chk("retrig_pc_n", 128'(we_n[3]), 128'(1));
        chk("retrig_done_n", 128'(done_n), 128'(1));
        chk("retrig_done_cycle", 128'(done_k), 128'(6));
        chk("retrig_stall_cycles", 128'(stall_n), 128'(6));
        $display("retrigger: %0d done pulses", done_n);

        // Reset right after psw_we
        run_seq(16'h7FF0, 16'hFFFF, 0, 0, 3, 10);
        chk("rst_cex_n", 128'(we_n[0]), 128'(1));
        chk("rst_psw_n", 128'(we_n[1]), 128'(1));
        chk("rst_lr_n", 128'(we_n[2]), 128'(0));
        chk("rst_pc_n", 128'(we_n[3]), 128'(0));
        chk("rst_done_n", 128'(done_n), 128'(0));
        $display("reset mid-sequence: lr/pc strobes %0d/%0d", we_n[2], we_n[3]);

        run_seq(16'h7FF0, 16'hFFFF, 0, 0, 0, 12);
        chk_pop(0, 2, 16'h0003, 16'h7FF2);
        chk_pop(3, 5, 16'h0A00, 16'h7FF8);
        chk("restart_done_cycle", 128'(done_k), 128'(6));
        $display("restart after reset: done at T+%0d", done_k);

        // SP wrap
        run_seq(16'hFFFA, 16'hFFFF, 0, 0, 0, 12);
        chk_pop(0, 2, 16'hC0DE, 16'hFFFC);
        chk_pop(1, 3, 16'h5A5A, 16'hFFFE);
`ifdef IV_EXIT_SP_WRAP_CHECK_EN
        chk("wrap_lr_n", 128'(we_n[2]), 128'(0));
        chk("wrap_pc_n", 128'(we_n[3]), 128'(0));
        chk("wrap_fault_cycle", 128'(fault_k), 128'(4));
        chk("wrap_fault_n", 128'(fault_n), 128'(1));
        chk("wrap_done_cycle", 128'(done_k), 128'(5));
        chk("wrap_req_cycles", 128'(req_n), 128'(2));
`else
        chk_pop(2, 4, 16'h1111, 16'h0000);
        chk_pop(3, 5, 16'h2222, 16'h0002);
        chk("wrap_done_cycle", 128'(done_k), 128'(6));
        chk("wrap_fault_n", 128'(fault_n), 128'(0));
`endif
        $display("sp wrap: done at T+%0d fault pulses %0d", done_k, fault_n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
